write_reg_hazard: RTL and testbench

WRITE_REG_HAZARD -- requirements
Module: write_reg_hazard

---
 rtl/write_reg_hazard.sv | 90 +++++++++
 tb/tb_write_reg_hazard.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/write_reg_hazard.sv
// Hazard unit for a five-stage pipeline.
// It carries WriteReg, RegWrite and MemtoReg from Execute through Memory to
// Writeback, then derives forwarding selects and stall/flush controls from
// those copies. Register 0 never forwards and never stalls.
module write_reg_hazard (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic       BranchD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic       RegWriteE,
    input  logic       MemtoRegE,
    output logic [4:0] WriteRegM,
    output logic [4:0] WriteRegW,
    output logic       RegWriteM,
    output logic       RegWriteW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushE
);

    logic memtoRegM;
    logic lwStall;
    logic branchStall;
    logic decodeHitsE;
    logic decodeHitsM;

    // Shift the destination bookkeeping E->M->W every cycle; FlushE is
    // deliberately ignored here because the bubble arrives from ID/EX.
    always_ff @(posedge clock) begin
        if (reset) begin
            WriteRegM <= 5'd0;
            RegWriteM <= 1'b0;
            memtoRegM <= 1'b0;
            WriteRegW <= 5'd0;
            RegWriteW <= 1'b0;
        end else begin
            WriteRegM <= WriteRegE;
            RegWriteM <= RegWriteE;
            memtoRegM <= MemtoRegE;
            WriteRegW <= WriteRegM;
            RegWriteW <= RegWriteM;
        end
    end

    // Execute operand selects: the Memory stage is younger, so it wins.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RsE != 5'd0 && RegWriteM && RsE == WriteRegM) begin
            ForwardAE = 2'b10;
        end else if (RsE != 5'd0 && RegWriteW && RsE == WriteRegW) begin
            ForwardAE = 2'b01;
        end
        if (RtE != 5'd0 && RegWriteM && RtE == WriteRegM) begin
            ForwardBE = 2'b10;
        end else if (RtE != 5'd0 && RegWriteW && RtE == WriteRegW) begin
            ForwardBE = 2'b01;
        end
    end

    // The Decode branch comparator can only take the Memory-stage ALU result.
    always_comb begin
        ForwardAD = (RsD != 5'd0) && RegWriteM && (RsD == WriteRegM);
        ForwardBD = (RtD != 5'd0) && RegWriteM && (RtD == WriteRegM);
    end

    // Stall on a load-use pair, or on a branch whose operands are not yet
    // available to the Decode comparator; PC, IF/ID and ID/EX act together.
    always_comb begin
        decodeHitsE = (WriteRegE != 5'd0) &&
                      ((WriteRegE == RsD) || (WriteRegE == RtD));
        decodeHitsM = (WriteRegM != 5'd0) &&
                      ((WriteRegM == RsD) || (WriteRegM == RtD));
        lwStall     = MemtoRegE && decodeHitsE;
        branchStall = BranchD && ((RegWriteE && decodeHitsE) ||
                                  (memtoRegM && decodeHitsM));
        StallF      = lwStall || branchStall;
        StallD      = lwStall || branchStall;
        FlushE      = lwStall || branchStall;
    end

endmodule

// File: tb/tb_write_reg_hazard.sv
// Self-checking bench for write_reg_hazard: directed pipeline scenarios
// followed by a randomized stretch, with a reference model feeding a
// scoreboard of expected output vectors.
module tb_write_reg_hazard;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE;
    logic       BranchD, RegWriteE, MemtoRegE;
    logic [4:0] WriteRegM, WriteRegW;
    logic       RegWriteM, RegWriteW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       ForwardAD, ForwardBD;
    logic       StallF, StallD, FlushE;

    int passCount  = 0;
    int checkCount = 0;

    typedef struct {
        string       tag;
        logic [20:0] expected;
    } sbEntry_t;

    sbEntry_t sbQueue[$];

    logic [4:0] mWriteRegM = 5'd0;
    logic [4:0] mWriteRegW = 5'd0;
    logic       mRegWriteM = 1'b0;
    logic       mRegWriteW = 1'b0;
    logic       mMemtoRegM = 1'b0;

    write_reg_hazard dut (
        .clock     (clock),
        .reset     (reset),
        .RsD       (RsD),
        .RtD       (RtD),
        .BranchD   (BranchD),
        .RsE       (RsE),
        .RtE       (RtE),
        .WriteRegE (WriteRegE),
        .RegWriteE (RegWriteE),
        .MemtoRegE (MemtoRegE),
        .WriteRegM (WriteRegM),
        .WriteRegW (WriteRegW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .ForwardAD (ForwardAD),
        .ForwardBD (ForwardBD),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushE    (FlushE)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [1:0] modelFwdE(input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        if (mRegWriteM && src == mWriteRegM) return 2'b10;
        if (mRegWriteW && src == mWriteRegW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [20:0] predict();
        logic lw, br, hitE, hitM, stall, fad, fbd;
        hitE  = (WriteRegE == RsD || WriteRegE == RtD) && WriteRegE != 5'd0;
        hitM  = (mWriteRegM == RsD || mWriteRegM == RtD) && mWriteRegM != 5'd0;
        lw    = MemtoRegE && hitE;
        br    = BranchD && ((RegWriteE && hitE) || (mMemtoRegM && hitM));
        stall = lw | br;
        fad   = (RsD != 5'd0) && mRegWriteM && (RsD == mWriteRegM);
        fbd   = (RtD != 5'd0) && mRegWriteM && (RtD == mWriteRegM);
        return {mWriteRegM, mWriteRegW, mRegWriteM, mRegWriteW,
                modelFwdE(RsE), modelFwdE(RtE), fad, fbd, stall, stall, stall};
    endfunction

    function automatic logic [20:0] dutVec();
        return {WriteRegM, WriteRegW, RegWriteM, RegWriteW, ForwardAE, ForwardBE,
                ForwardAD, ForwardBD, StallF, StallD, FlushE};
    endfunction

    task automatic setIdle();
        RsD = 5'd0; RtD = 5'd0; BranchD = 1'b0;
        RsE = 5'd0; RtE = 5'd0; WriteRegE = 5'd0;
        RegWriteE = 1'b0; MemtoRegE = 1'b0;
    endtask

    // Pop the oldest expectation and compare it with the settled DUT outputs.
    task automatic checkOutput();
        sbEntry_t entry;
        logic [20:0] observed;
        if (sbQueue.size() == 0) begin
            checkCount++;
            $error("[TB] FAIL scoreboard: observed empty queue, required one entry");
            return;
        end
        entry    = sbQueue.pop_front();
        observed = dutVec();
        checkCount++;
        assert (observed === entry.expected) passCount++;
        else $error("[TB] FAIL %s: observed %h required %h", entry.tag, observed, entry.expected);
    endtask

    // Push the model prediction for the current inputs, then sample mid-cycle.
    task automatic applyStimulus(input string tag);
        sbQueue.push_back('{tag, predict()});
        @(negedge clock);
        checkOutput();
    endtask

    task automatic checkValue(input string tag, input logic [4:0] observed,
                              input logic [4:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0d required %0d", tag, observed, expected);
    endtask

    // Take the rising edge and step the reference pipeline alongside the DUT.
    task automatic advance();
        @(posedge clock);
        if (reset) begin
            mWriteRegM = 5'd0; mWriteRegW = 5'd0;
            mRegWriteM = 1'b0; mRegWriteW = 1'b0; mMemtoRegM = 1'b0;
        end else begin
            mWriteRegW = mWriteRegM;
            mRegWriteW = mRegWriteM;
            mWriteRegM = WriteRegE;
            mRegWriteM = RegWriteE;
            mMemtoRegM = MemtoRegE;
        end
        #1;
    endtask

    initial begin
        setIdle();
        reset = 1'b1;
        advance();
        reset = 1'b0;

        $display("[TB] reset state");
        applyStimulus("resetState");
        checkValue("resetWriteRegM", WriteRegM, 5'd0);
        checkValue("resetStall", {4'd0, StallF}, 5'd0);
        advance();

        $display("[TB] ALU back-to-back");
        WriteRegE = 5'd8; RegWriteE = 1'b1;
        applyStimulus("aluProducer");
        advance();
        setIdle(); RsE = 5'd8;
        applyStimulus("aluFwdMem");
        checkValue("aluFwdAEMem", {3'd0, ForwardAE}, 5'd2);
        advance();
        applyStimulus("aluFwdWb");
        checkValue("aluFwdAEWb", {3'd0, ForwardAE}, 5'd1);
        advance();

        $display("[TB] double match");
        setIdle(); WriteRegE = 5'd9; RegWriteE = 1'b1;
        applyStimulus("dblFirst");
        advance();
        applyStimulus("dblSecond");
        advance();
        setIdle(); RtE = 5'd9;
        applyStimulus("dblConsumer");
        checkValue("dblFwdBE", {3'd0, ForwardBE}, 5'd2);
        advance();

        $display("[TB] load-use");
        setIdle(); MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd5; RtD = 5'd5;
        applyStimulus("loadUseStall");
        checkValue("loadUseStallF", {2'd0, StallF, StallD, FlushE}, 5'd7);
        advance();
        setIdle(); RtD = 5'd5; RtE = 5'd5;
        applyStimulus("loadUseBubble");
        checkValue("loadUseNoStall", {4'd0, StallF}, 5'd0);
        checkValue("loadUseFwdBE", {3'd0, ForwardBE}, 5'd2);
        advance();
        setIdle(); RtE = 5'd5;
        applyStimulus("loadUseWb");
        checkValue("loadUseFwdBEWb", {3'd0, ForwardBE}, 5'd1);
        advance();

        $display("[TB] branch after ALU");
        setIdle(); BranchD = 1'b1; RsD = 5'd4; RegWriteE = 1'b1; WriteRegE = 5'd4;
        applyStimulus("branchStall");
        checkValue("branchStallD", {4'd0, StallD}, 5'd1);
        advance();
        setIdle(); BranchD = 1'b1; RsD = 5'd4;
        applyStimulus("branchFwd");
        checkValue("branchFwdAD", {4'd0, ForwardAD}, 5'd1);
        checkValue("branchWriteRegM", WriteRegM, 5'd4);
        checkValue("branchNoStall", {4'd0, FlushE}, 5'd0);
        advance();

        $display("[TB] register zero");
        setIdle(); RegWriteE = 1'b1; MemtoRegE = 1'b1; BranchD = 1'b1;
        applyStimulus("zeroNoStall");
        checkValue("zeroStallF", {4'd0, StallF}, 5'd0);
        advance();
        setIdle(); BranchD = 1'b1;
        applyStimulus("zeroMemStage");
        checkValue("zeroBranchStall", {4'd0, StallF}, 5'd0);
        advance();
        setIdle();
        applyStimulus("zeroWbStage");
        checkValue("zeroFwdAE", {3'd0, ForwardAE}, 5'd0);
        advance();

        $display("[TB] reset mid-flight");
        setIdle(); WriteRegE = 5'd7; RegWriteE = 1'b1;
        applyStimulus("midProducer");
        advance();
        setIdle();
        applyStimulus("midInFlight");
        checkValue("midRegWriteM", {4'd0, RegWriteM}, 5'd1);
        checkValue("midWriteRegM", WriteRegM, 5'd7);
        reset = 1'b1;
        advance();
        reset = 1'b0;
        RsE = 5'd7; RtE = 5'd7; RsD = 5'd7; RtD = 5'd7;
        applyStimulus("midAfterReset");
        checkValue("midRegWriteMW", {3'd0, RegWriteM, RegWriteW}, 5'd0);
        checkValue("midWriteRegW", WriteRegW, 5'd0);
        checkValue("midFwd", {1'b0, ForwardAE, ForwardBE}, 5'd0);
        advance();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 29) == 0);
            RsD       = 5'($urandom_range(0, 3));
            RtD       = 5'($urandom_range(0, 3));
            RsE       = 5'($urandom_range(0, 3));
            RtE       = 5'($urandom_range(0, 3));
            WriteRegE = 5'($urandom_range(0, 3));
            BranchD   = 1'($urandom_range(0, 1));
            RegWriteE = 1'($urandom_range(0, 1));
            MemtoRegE = 1'($urandom_range(0, 1));
            applyStimulus("random");
            advance();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
